regfile_write_arbiter: RTL and testbench

Shares the single register-file write port between NREQ requesters (ALU result, load unit, etc.) using round-robin arbitration. The granted 3-bit destination address is decoded 3:8 into a one-hot write-enable bus that drives the eight registers. A req/ack handshake sequences the writes, and every output is registered. The block sits between the execute stage and the 8-entry register file.

---
 rtl/regfile_write_arbiter_if.sv | 27 ++
 rtl/regfile_write_arbiter.sv | 114 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bus between the requesters and the register-file write arbiter.
// The requester side is the master; the arbiter is the slave.
interface regfile_write_arbiter_if #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
);
    logic                         enable;
    logic [NREQ-1:0]              req;
    logic [3*NREQ-1:0]            addr_flat;
    logic [DATA_WIDTH*NREQ-1:0]   data_flat;
    logic [NREQ-1:0]              ack;
    logic [7:0]                   we;
    logic [DATA_WIDTH-1:0]        wdata;
    logic [ID_WIDTH-1:0]          grant_id;
    logic                         busy;

    modport master (
        output enable, req, addr_flat, data_flat,
        input  ack, we, wdata, grant_id, busy
    );

    modport slave (
        input  enable, req, addr_flat, data_flat,
        output ack, we, wdata, grant_id, busy
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the shared register-file write port.
// All outputs are registered; each write takes one IDLE and one WRITE cycle.
module regfile_write_arbiter #(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
) (
    input logic                    clock,
    input logic                    reset_n,
    regfile_write_arbiter_if.slave bus
);
    localparam int SW = ID_WIDTH + 1;

    typedef enum logic {IDLE, WRITE} state_e;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]            we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NREQ-1:0]       ack_q, ack_d;
    logic [ID_WIDTH-1:0]   grant_id_q, grant_id_d;
    logic                  busy_q, busy_d;

    logic                  found;
    logic [ID_WIDTH-1:0]   win;
    logic [2:0]            win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    logic [SW-1:0]         idx;
    logic [SW-1:0]         nxt;

    // Search from rr_ptr upward with wrap; first requester found wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = SW'(rr_ptr_q) + SW'(k);
            if (idx >= SW'(NREQ)) idx = idx - SW'(NREQ);
            if (!found && bus.req[ID_WIDTH'(idx)]) begin
                found = 1'b1;
                win   = ID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ID_WIDTH'(i) == win) begin
                win_addr = bus.addr_flat[3*i +: 3];
                win_data = bus.data_flat[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        nxt = SW'(grant_id_q) + SW'(1);
        if (nxt >= SW'(NREQ)) nxt = '0;
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        we_d       = '0;
        wdata_d    = wdata_q;
        ack_d      = '0;
        grant_id_d = grant_id_q;
        busy_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable && found) begin
                    state_d    = WRITE;
                    we_d       = 8'd1 << win_addr;
                    wdata_d    = win_data;
                    grant_id_d = win;
                    busy_d     = 1'b1;
                    for (int i = 0; i < NREQ; i++)
                        ack_d[i] = (ID_WIDTH'(i) == win);
                end
            end
            WRITE: begin
                state_d  = IDLE;
                rr_ptr_d = ID_WIDTH'(nxt);
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            we_q       <= '0;
            wdata_q    <= '0;
            ack_q      <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            ack_q      <= ack_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.we       = we_q;
    assign bus.wdata    = wdata_q;
    assign bus.ack      = ack_q;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, single write,
// round-robin order, pointer wrap, stall, address decode, reset mid-write.
module tb_regfile_write_arbiter;
    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    regfile_write_arbiter_if #(
        .NREQ(4), .DATA_WIDTH(32), .ID_WIDTH(2)
    ) rf_if ();

    regfile_write_arbiter #(
        .NREQ(4), .DATA_WIDTH(32), .ID_WIDTH(2)
    ) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_rq(input int i, input logic [2:0] a,
                          input logic [31:0] d);
        rf_if.addr_flat[3*i +: 3]  = a;
        rf_if.data_flat[32*i +: 32] = d;
    endtask

    initial begin
        logic [3:0] exp_ack;
        logic [7:0] exp_we;
        int         seq [5];
        n_pass  = 0;
        n_total = 0;
        seq = '{0, 1, 2, 3, 0};
        rst_n = 1'b1;
        rf_if.enable    = 1'b1;
        rf_if.req       = 4'b1111;
        rf_if.addr_flat = '0;
        rf_if.data_flat = '0;
        for (int i = 0; i < 4; i++)
            set_rq(i, 3'(i + 1), 32'h1000_0000 | 32'(i));

        // asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk("rst_we", 32'(rf_if.we), 32'h0);
        chk("rst_ack", 32'(rf_if.ack), 32'h0);
        chk("rst_busy", 32'(rf_if.busy), 32'h0);
        chk("rst_wdata", rf_if.wdata, 32'h0);
        chk("rst_gid", 32'(rf_if.grant_id), 32'h0);
        step();
        step();
        chk("rst_hold_ack", 32'(rf_if.ack), 32'h0);
        chk("rst_hold_we", 32'(rf_if.we), 32'h0);
        rst_n = 1'b1;

        // round robin, all requesting
        foreach (seq[j]) begin
            exp_ack = 4'b0001 << seq[j];
            exp_we  = 8'b1 << (seq[j] + 1);
            step();
            chk("rr_gid", 32'(rf_if.grant_id), 32'(seq[j]));
            chk("rr_ack", 32'(rf_if.ack), 32'(exp_ack));
            chk("rr_we", 32'(rf_if.we), 32'(exp_we));
            chk("rr_wdata", rf_if.wdata, 32'h1000_0000 | 32'(seq[j]));
            step();
            chk("rr_gap_busy", 32'(rf_if.busy), 32'h0);
        end

        // single write
        rf_if.req = 4'b0001;
        set_rq(0, 3'd5, 32'hDEAD_BEEF);
        step();
        chk("sw_we", 32'(rf_if.we), 32'h20);
        chk("sw_wdata", rf_if.wdata, 32'hDEAD_BEEF);
        chk("sw_ack", 32'(rf_if.ack), 32'h1);
        chk("sw_gid", 32'(rf_if.grant_id), 32'h0);
        chk("sw_busy", 32'(rf_if.busy), 32'h1);
        rf_if.req = 4'b0000;
        step();
        chk("sw_after_we", 32'(rf_if.we), 32'h0);
        chk("sw_after_ack", 32'(rf_if.ack), 32'h0);
        chk("sw_after_busy", 32'(rf_if.busy), 32'h0);
        chk("sw_after_wdata", rf_if.wdata, 32'hDEAD_BEEF);
        chk("sw_after_gid", 32'(rf_if.grant_id), 32'h0);

        // pointer wrap
        rf_if.req = 4'b0100;
        step();
        chk("wrap_g2", 32'(rf_if.grant_id), 32'd2);
        rf_if.req = 4'b0101;
        step();
        step();
        chk("wrap_g0", 32'(rf_if.grant_id), 32'd0);
        chk("wrap_g0_ack", 32'(rf_if.ack), 32'h1);
        rf_if.req = 4'b0100;
        step();
        step();
        chk("wrap_g2b", 32'(rf_if.grant_id), 32'd2);
        chk("wrap_g2b_ack", 32'(rf_if.ack), 32'h4);
        rf_if.req = 4'b0000;
        step();

        // stall with enable low
        rf_if.enable = 1'b0;
        rf_if.req    = 4'b0010;
        set_rq(1, 3'd3, 32'hCAFE_0001);
        for (int c = 0; c < 10; c++) begin
            step();
            chk("stall_we", 32'(rf_if.we), 32'h0);
        end
        rf_if.enable = 1'b1;
        step();
        chk("unstall_ack", 32'(rf_if.ack), 32'h2);
        chk("unstall_we", 32'(rf_if.we), 32'h08);
        step();

        // address decode sweep via requester 1
        for (int a = 0; a < 8; a++) begin
            set_rq(1, 3'(a), 32'hA000_0000 | 32'(a));
            step();
            exp_we = 8'b1 << a;
            chk("dec_we", 32'(rf_if.we), 32'(exp_we));
            chk("dec_ack", 32'(rf_if.ack), 32'h2);
            step();
        end
        rf_if.req = 4'b0000;
        step();

        // reset during WRITE
        rf_if.req = 4'b0001;
        step();
        chk("rw_busy", 32'(rf_if.busy), 32'h1);
        rf_if.req = 4'b1010;
        #2 rst_n = 1'b0;
        #1;
        chk("rw_we", 32'(rf_if.we), 32'h0);
        chk("rw_ack", 32'(rf_if.ack), 32'h0);
        chk("rw_busy0", 32'(rf_if.busy), 32'h0);
        step();
        chk("rw_noack", 32'(rf_if.ack), 32'h0);
        step();
        chk("rw_noack2", 32'(rf_if.ack), 32'h0);
        rst_n = 1'b1;
        step();
        chk("rw_gid", 32'(rf_if.grant_id), 32'd1);
        chk("rw_ack2", 32'(rf_if.ack), 32'h2);
        rf_if.req = 4'b0000;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
